// File: rtl/generic_if_fifo_pkg.sv
// Shared constants and types for generic_if_fifo.
// Width constants specialise WIDTH for each variant of the generic data interface.
package generic_if_fifo_pkg;

  localparam int unsigned IfWidthBit    = 1;
  localparam int unsigned IfWidthNibble = 4;
  localparam int unsigned IfWidthByte   = 8;
  localparam int unsigned IfWidthWord   = 32;

  // Encoded as {write, read} so it can be cast directly from the two enables.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/generic_if_fifo_ptr.sv
// Wrapping pointer register with increment enable and synchronous clear.
// Wraps modulo 2**Width; the owner sizes Width so that this equals the FIFO depth.
module generic_if_fifo_ptr #(
  parameter int unsigned Width = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [Width-1:0] o_ptr
);

  logic [Width-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clear) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = ptr_q + Width'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/generic_if_fifo.sv
// Synchronous ready/valid FIFO with first-word fall-through on the pop side.
// Define GENERIC_IF_FIFO_BYPASS_EN for a 0-cycle empty-FIFO bypass path.
module generic_if_fifo
  import generic_if_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = IfWidthBit,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_push_valid,
  output logic                       o_push_ready,
  input  logic [WIDTH-1:0]           i_push_data,
  output logic                       o_pop_valid,
  input  logic                       i_pop_ready,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FullCnt  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfullCnt = CNT_W'(AFULL_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, bypass_avail, wr_en, rd_en;
  fifo_op_e         op;

  assign empty = (count_q == '0);

`ifdef GENERIC_IF_FIFO_BYPASS_EN
  assign bypass_avail = empty & i_push_valid & ~i_clear;
`else
  assign bypass_avail = 1'b0;
`endif

  // Ready depends only on registered count: a full FIFO refuses even with a concurrent pop.
  assign o_push_ready  = (count_q != FullCnt);
  assign o_pop_valid   = ~empty | bypass_avail;
  assign o_pop_data    = bypass_avail ? i_push_data : mem_q[rd_ptr];
  assign o_count       = count_q;
  assign o_almost_full = (count_q >= AfullCnt);

  // A word consumed through the bypass is never written.
  assign wr_en = i_push_valid & o_push_ready & ~i_clear & ~(bypass_avail & i_pop_ready);
  assign rd_en = ~empty & i_pop_ready & ~i_clear;
  assign op    = fifo_op_e'({wr_en, rd_en});

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else begin
      unique case (op)
        OpPush:  count_d = count_q + CNT_W'(1);
        OpPop:   count_d = count_q - CNT_W'(1);
        OpBoth:  count_d = count_q;
        OpNone:  count_d = count_q;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr] <= i_push_data;
    end
  end

  generic_if_fifo_ptr #(
    .Width(PTR_W)
  ) u_wr_ptr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(i_clear),
    .i_inc  (wr_en),
    .o_ptr  (wr_ptr)
  );

  generic_if_fifo_ptr #(
    .Width(PTR_W)
  ) u_rd_ptr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(i_clear),
    .i_inc  (rd_en),
    .o_ptr  (rd_ptr)
  );

endmodule

// File: tb/tb_generic_if_fifo.sv
// Self-checking bench for generic_if_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_generic_if_fifo;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int AF = 3;
`ifdef GENERIC_IF_FIFO_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, clear, push_valid, push_ready, pop_valid, pop_ready, afull;
  logic [W-1:0] push_data, pop_data;
  logic [2:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  generic_if_fifo #(
    .WIDTH(W),
    .DEPTH(D),
    .AFULL_THRESH(AF)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clear      (clear),
    .i_push_valid (push_valid),
    .o_push_ready (push_ready),
    .i_push_data  (push_data),
    .o_pop_valid  (pop_valid),
    .i_pop_ready  (pop_ready),
    .o_pop_data   (pop_data),
    .o_count      (count),
    .o_almost_full(afull)
  );

  task automatic drive(input logic pv, input logic [W-1:0] pd, input logic pr, input logic clr);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    clear      = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO of capacity D; clear wins; full refuses pushes regardless of pops.
  function automatic void model_edge();
    int sz;
    sz = q.size();
    if (clear) begin
      q.delete();
    end else if (!(Byp && sz == 0 && push_valid && pop_ready)) begin
      if (sz != 0 && pop_ready) void'(q.pop_front());
      if (push_valid && sz != D) q.push_back(push_data);
    end
  endfunction

  task automatic test_reset();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_init_count: got %0d want 0", count); end
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL rst_init_pop_valid: got %b want 0", pop_valid); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL rst_init_push_ready: got %b want 1", push_ready); end
    n_checks++; if (afull !== 1'b0) begin n_fail++; $display("FAIL rst_init_afull: got %b want 0", afull); end
    n_checks++; if (pop_data !== 4'd0) begin n_fail++; $display("FAIL rst_init_pop_data: got %0h want 0", pop_data); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(9 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rst_preload_count: got %0d want 3", count); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d want 0", count); end
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_pop_valid: got %b want 0", pop_valid); end
    n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_push_ready: got %b want 1", push_ready); end
    n_checks++; if (pop_data !== 4'd0) begin n_fail++; $display("FAIL rst_async_pop_data: got %0h want 0", pop_data); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals = '{4'd1, 4'd2, 4'd3, 4'd0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      tick();
      n_checks++; if (afull !== (i >= 2)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, afull, (i >= 2)); end
      n_checks++; if (push_ready !== (i != 3)) begin n_fail++; $display("FAIL fill_push_ready[%0d]: got %b want %b", i, push_ready, (i != 3)); end
    end
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_refused_count: got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (pop_valid !== 1'b1 || pop_data !== vals[i]) begin n_fail++; $display("FAIL drain_word[%0d]: got v=%b d=%0h want v=1 d=%0h", i, pop_valid, pop_data, vals[i]); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (pop_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got v=%b cnt=%0d want v=0 cnt=0", pop_valid, count); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k < 10; k++) begin
      drive(1'b1, W'(k), 1'b1, 1'b0);
      n_checks++; if (pop_data !== W'(k - 1)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0h want %0h", k, pop_data, W'(k - 1)); end
      tick();
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, count); end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (pop_data !== 4'd9) begin n_fail++; $display("FAIL wrap_last: got %0h want 9", pop_data); end
    tick();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_end_count: got %0d want 0", count); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(4 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'd8, 1'b1, 1'b0);
    n_checks++; if (push_ready !== 1'b0 || pop_data !== 4'd4) begin n_fail++; $display("FAIL fullpop_pre: got rdy=%b d=%0h want rdy=0 d=4", push_ready, pop_data); end
    tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (pop_data !== W'(5 + i)) begin n_fail++; $display("FAIL fullpop_drain[%0d]: got %0h want %0h", i, pop_data, W'(5 + i)); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b want 0", pop_valid); end
  endtask

  task automatic test_clear();
    drive(1'b1, 4'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd9, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL clear_state: got cnt=%0d v=%b want cnt=0 v=0", count, pop_valid); end
    drive(1'b1, 4'd7, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (pop_data !== 4'd7) begin n_fail++; $display("FAIL clear_dropped_push: got %0h want 7", pop_data); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL clear_end_count: got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd5, 1'b1, 1'b0);
`ifdef GENERIC_IF_FIFO_BYPASS_EN
    n_checks++; if (pop_valid !== 1'b1 || pop_data !== 4'd5) begin n_fail++; $display("FAIL bypass_same_cycle: got v=%b d=%0h want v=1 d=5", pop_valid, pop_data); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd0 || pop_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_no_write: got cnt=%0d v=%b want cnt=0 v=0", count, pop_valid); end
`else
    n_checks++; if (pop_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_push_cycle: got %b want 0", pop_valid); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (pop_valid !== 1'b1 || pop_data !== 4'd5 || count !== 3'd1) begin n_fail++; $display("FAIL nobypass_next_cycle: got v=%b d=%0h cnt=%0d want v=1 d=5 cnt=1", pop_valid, pop_data, count); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic       exp_v;
    logic [W-1:0] exp_d;
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 99) < 60), W'($urandom), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3));
      exp_v = (q.size() != 0) || (Byp && push_valid && !clear);
      exp_d = (q.size() != 0) ? q[0] : push_data;
      n_checks++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, count, q.size()); end
      n_checks++; if (push_ready !== (q.size() != D)) begin n_fail++; $display("FAIL rand_push_ready[%0d]: got %b want %b", c, push_ready, (q.size() != D)); end
      n_checks++; if (afull !== (q.size() >= AF)) begin n_fail++; $display("FAIL rand_afull[%0d]: got %b want %b", c, afull, (q.size() >= AF)); end
      n_checks++; if (pop_valid !== exp_v) begin n_fail++; $display("FAIL rand_pop_valid[%0d]: got %b want %b", c, pop_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (pop_data !== exp_d) begin n_fail++; $display("FAIL rand_pop_data[%0d]: got %0h want %0h", c, pop_data, exp_d); end
      end
      model_edge();
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_ready  = 1'b0;
    tick();
    tick();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_clear();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
